ram_arbiter: RTL and testbench

- Shares the single-port data RAM between NUM_CORES processing units so matrix-multiply work can be split across cores.
- Each core presents one request at a time: address, write enable and write data, held until acknowledged.
- Round-robin arbitration with a registered grant and 1-cycle synchronous RAM read latency.
- Sits between the processing-unit array and the data RAM; replaces the direct CPU_ADDRESS/CPU_DATA/CPU_WRITE_EN connection.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_rr_picker.sv | 51 +++++
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encodings and default widths.
// Optional build macro used by this block: ARB_FIXED_PRIO_EN (see rr_picker).
package ram_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational winner selection among masked requests.
// Round-robin from a start pointer by default; ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] mask,
    input  logic [IDX_W-1:0]     start,
    output logic                 valid,
    output logic [IDX_W-1:0]     index
);

    logic [NUM_CORES-1:0] elig;

    assign elig = req & ~mask;

`ifdef ARB_FIXED_PRIO_EN
    logic unused_start;
    assign unused_start = ^start;

    // Scan downward so the lowest eligible index is the last one written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] cand;

    // Scan offsets downward so the candidate nearest to start wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(start) + off) % NUM_CORES);
            if (elig[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between NUM_CORES cores: IDLE -> ACCESS -> RESP handshake,
// registered grant, read data captured at the end of ACCESS. Build option: ARB_FIXED_PRIO_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ram_arbiter_pkg::ADDR_W,
    parameter int DATA_W    = ram_arbiter_pkg::DATA_W,
    localparam int IDX_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_we,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy
);

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     next_ptr;
    logic [IDX_W-1:0]     pick_start;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_CORES-1:0] pick_mask;
    logic [NUM_CORES-1:0] grant_oh;
    logic                 pick_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_we;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_CORES - 1) ? '0 : IDX_W'(int'(idx) + 1);
    endfunction

    assign next_ptr = wrap_inc(grant_id);

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_oh[i] = (grant_id == IDX_W'(i));
        end
    end

    // In RESP the current grantee sits out one arbitration and the search starts past it.
    always_comb begin
        if (state == ARB_RESP) begin
            pick_mask  = grant_oh;
            pick_start = next_ptr;
        end else begin
            pick_mask  = '0;
            pick_start = rr_ptr;
        end
    end

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (core_req),
        .mask  (pick_mask),
        .start (pick_start),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
                sel_we    = core_we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            core_ack   <= '0;
            core_rdata <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            core_ack <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_we    <= sel_we;
                        busy      <= 1'b1;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    ram_we     <= 1'b0;
                    core_rdata <= ram_rdata;
                    core_ack   <= grant_oh;
                    state      <= ARB_RESP;
                end
                ARB_RESP: begin
`ifdef ARB_FIXED_PRIO_EN
                    rr_ptr <= '0;
`else
                    rr_ptr <= next_ptr;
`endif
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_we    <= sel_we;
                        state     <= ARB_ACCESS;
                    end else begin
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    ram_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter (default round-robin build) with a behavioural RAM.
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    c_req;
    logic [N-1:0]    c_we;
    logic [AW-1:0]   c_addr [N];
    logic [DW-1:0]   c_wdata[N];
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_ack;
    logic [DW-1:0]   core_rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;
    logic [1:0]      grant_id;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int rem[N];

    typedef struct packed {
        logic [N-1:0]  ack;
        logic          chk_data;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sbq[$];

    bit [DW-1:0] mem     [65536];
    bit          wr_flag [65536];

    always #5 clk = ~clk;

    ram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (c_req),
        .core_we    (c_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always_comb begin
        core_addr  = '0;
        core_wdata = '0;
        for (int i = 0; i < N; i++) begin
            core_addr[i*AW +: AW]  = c_addr[i];
            core_wdata[i*DW +: DW] = c_wdata[i];
        end
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 16'h0010) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    // RAM address register is ram_addr itself, so data follows one cycle after the grant edge.
    assign ram_rdata = wr_flag[ram_addr] ? mem[ram_addr] : init_val(ram_addr);

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_flag[ram_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] ack, input logic chk_data, input logic [DW-1:0] data);
        exp_t e;
        e.ack      = ack;
        e.chk_data = chk_data;
        e.data     = data;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (core_ack !== '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 32'(core_ack), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ack_core", 32'(core_ack), 32'(e.ack));
                if (e.chk_data) chk("ack_rdata", 32'(core_rdata), 32'(e.data));
            end
        end
    end

    // Drive held requests; on each ack a core either retires or moves to its next address.
    task automatic run_reqs(input int budget);
        int last = -1;
        int cyc  = 0;
        logic [N-1:0] ackv;
        while (c_req != '0 && cyc < budget) begin
            @(negedge clk);
            ackv = core_ack;
            if (ackv != '0) begin
                if (last >= 0) chk("ack_spacing", 32'(cyc - last), 32'd2);
                last = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (ackv[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) c_req[i] = 1'b0;
                    else c_addr[i] = c_addr[i] + 16'd1;
                end
            end
        end
        if (c_req != '0) begin
            chk("run_timeout", 32'(c_req), 32'd0);
            c_req = '0;
        end
    endtask

    task automatic reset_dut(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        c_req = '0;
        c_we  = '0;
        for (int i = 0; i < N; i++) begin
            c_addr[i]  = '0;
            c_wdata[i] = '0;
            rem[i]     = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(core_ack), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_rdata", 32'(core_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read by core 2
        @(posedge clk); #1;
        c_req[2]  = 1'b1;
        c_we[2]   = 1'b0;
        c_addr[2] = 16'h0010;
        push_exp(4'b0100, 1'b1, 8'hA5);
        @(negedge clk);
        chk("rd_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rd_addr", 32'(ram_addr), 32'h0010);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_gid", 32'(grant_id), 32'd2);
        @(negedge clk);
        chk("rd_ack_cycle", 32'(core_ack), 32'b0100);
        @(posedge clk); #1;
        c_req[2] = 1'b0;
        @(negedge clk);
        chk("rd_back_idle", 32'(busy), 32'd0);
        chk("rd_gid_hold", 32'(grant_id), 32'd2);

        // Single write by core 0, then read back by core 1
        @(posedge clk); #1;
        c_req[0]   = 1'b1;
        c_we[0]    = 1'b1;
        c_addr[0]  = 16'h0042;
        c_wdata[0] = 8'h3C;
        push_exp(4'b0001, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("wr_we", 32'(ram_we), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'h0042);
        chk("wr_wdata", 32'(ram_wdata), 32'h3C);
        @(negedge clk);
        chk("wr_we_drop", 32'(ram_we), 32'd0);
        chk("wr_ack_cycle", 32'(core_ack), 32'b0001);
        @(posedge clk); #1;
        c_req[0] = 1'b0;
        c_we[0]  = 1'b0;
        c_req[1]  = 1'b1;
        c_addr[1] = 16'h0042;
        rem[1]    = 1;
        push_exp(4'b0010, 1'b1, 8'h3C);
        run_reqs(20);

        // Core 1 keeps requesting while core 3 waits
        @(posedge clk); #1;
        c_req[1]  = 1'b1;
        c_addr[1] = 16'h0020;
        rem[1]    = 2;
        push_exp(4'b0010, 1'b1, init_val(16'h0020));
        push_exp(4'b1000, 1'b1, init_val(16'h0030));
        push_exp(4'b0010, 1'b1, init_val(16'h0021));
        @(posedge clk); #1;
        c_req[3]  = 1'b1;
        c_addr[3] = 16'h0030;
        rem[3]    = 1;
        run_reqs(40);
        @(negedge clk);
        chk("rr_back_idle", 32'(busy), 32'd0);

        // Reset during ACCESS of a core 0 read
        @(posedge clk); #1;
        c_req[0]  = 1'b1;
        c_we[0]   = 1'b0;
        c_addr[0] = 16'h0050;
        @(posedge clk); #1;
        chk("mid_addr", 32'(ram_addr), 32'h0050);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ack", 32'(core_ack), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_addr_rst", 32'(ram_addr), 32'd0);
        chk("mid_wdata_rst", 32'(ram_wdata), 32'd0);
        chk("mid_rdata_rst", 32'(core_rdata), 32'd0);
        chk("mid_we", 32'(ram_we), 32'd0);
        chk("mid_gid", 32'(grant_id), 32'd0);
        rem[0] = 1;
        push_exp(4'b0001, 1'b1, init_val(16'h0050));
        run_reqs(20);

        // All four cores continuously, four accesses each
        reset_dut(2);
        for (int i = 0; i < N; i++) begin
            c_we[i]   = 1'b0;
            c_addr[i] = 16'((i + 1) * 16'h0100);
            rem[i]    = 4;
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                push_exp(4'(1 << i), 1'b1, init_val(16'((i + 1) * 16'h0100 + k)));
            end
        end
        c_req = 4'hF;
        run_reqs(100);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
